// File: rtl/ace_pkg.sv
// rtl/ace_pkg.sv - shared CRRESP constants, FSM state and response slice types
package ace_pkg;

    localparam int CR_DATA   = 0;
    localparam int CR_ERR    = 1;
    localparam int CR_DIRTY  = 2;
    localparam int CR_SHARED = 3;
    localparam int CR_UNIQUE = 4;
    localparam int CR_W      = 5;

    typedef logic [CR_W-1:0] cr_slice_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } snoop_state_t;

    // Response substituted for a master that never answered: Error only.
    localparam cr_slice_t CR_TIMEOUT_RESP = cr_slice_t'(1 << CR_ERR);

endpackage

// File: rtl/ace_snoop_bcast_if.sv
// rtl/ace_snoop_bcast_if.sv - request, AC/CR and aggregation-side signals of the snoop stage
interface ace_snoop_bcast_if #(
    parameter int NUM_MASTERS = 8,
    parameter int ADDR_WIDTH  = 44,
    parameter int MST_IDX_W   = 4
) ();

    logic                     req_valid;
    logic                     req_ready;
    logic [ADDR_WIDTH-1:0]    req_addr;
    logic [3:0]               req_snoop;
    logic [MST_IDX_W-1:0]     req_src;

    logic [NUM_MASTERS-1:0]   acvalid;
    logic [NUM_MASTERS-1:0]   acready;
    logic [ADDR_WIDTH-1:0]    acaddr;
    logic [3:0]               acsnoop;

    logic [NUM_MASTERS-1:0]   crvalid;
    logic [NUM_MASTERS-1:0]   crready;
    logic [NUM_MASTERS*5-1:0] crresp;

    logic [NUM_MASTERS-1:0]   crresp_vld;
    logic [NUM_MASTERS*5-1:0] crresp_bus;
    logic                     snoop_complete;
    logic                     timeout_err;
    logic                     release_pulse;

    modport slave (
        input  req_valid, req_addr, req_snoop, req_src,
        input  acready, crvalid, crresp, release_pulse,
        output req_ready, acvalid, acaddr, acsnoop, crready,
        output crresp_vld, crresp_bus, snoop_complete, timeout_err
    );

    modport master (
        output req_valid, req_addr, req_snoop, req_src,
        output acready, crvalid, crresp, release_pulse,
        input  req_ready, acvalid, acaddr, acsnoop, crready,
        input  crresp_vld, crresp_bus, snoop_complete, timeout_err
    );

endinterface

// File: rtl/ace_snoop_bcast_port_trk.sv
// rtl/ace_snoop_bcast_port_trk.sv - per-master AC/CR progress flags and captured response
module snoop_port_trk
    import ace_pkg::*;
(
    input  logic      ACLK,
    input  logic      ARESETn,
    input  logic      start,
    input  logic      is_src,
    input  logic      clear,
    input  logic      timeout,
    input  logic      acready,
    input  logic      crvalid,
    input  cr_slice_t crresp,
    output logic      acvalid,
    output logic      crready,
    output logic      crresp_vld,
    output cr_slice_t crresp_slice,
    output logic      cr_hs
);

    logic ac_done;
    logic cr_done;

    // Ready only between this master's AC handshake and its CR handshake; flops only.
    assign crready = ac_done & ~cr_done;
    assign cr_hs   = crvalid & crready;

    // Track one master through broadcast, response capture and forced completion.
    always_ff @(posedge ACLK) begin
        if (!ARESETn || clear) begin
            acvalid      <= 1'b0;
            ac_done      <= 1'b0;
            cr_done      <= 1'b0;
            crresp_vld   <= 1'b0;
            crresp_slice <= '0;
        end else if (start) begin
            // The initiator is not snooped: it counts as answered with an all-zero response.
            acvalid      <= ~is_src;
            ac_done      <= is_src;
            cr_done      <= is_src;
            crresp_vld   <= is_src;
            crresp_slice <= '0;
        end else begin
            if (acvalid && acready) begin
                acvalid <= 1'b0;
                ac_done <= 1'b1;
            end
            if (cr_hs) begin
                crresp_slice <= crresp;
                crresp_vld   <= 1'b1;
                cr_done      <= 1'b1;
            end
            if (timeout) begin
                // A real response arriving in the timeout cycle is kept.
                acvalid <= 1'b0;
                cr_done <= 1'b1;
                if (!crresp_vld && !cr_hs) begin
                    crresp_vld   <= 1'b1;
                    crresp_slice <= CR_TIMEOUT_RESP;
                end
            end
        end
    end

endmodule

// File: rtl/ace_snoop_bcast.sv
// rtl/ace_snoop_bcast.sv - snoop broadcast, CR collection and hold-until-release stage
module ace_snoop_bcast
    import ace_pkg::*;
#(
    parameter int NUM_MASTERS    = 8,
    parameter int ADDR_WIDTH     = 44,
    parameter int MST_IDX_W      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              ACLK,
    input logic              ARESETn,
    ace_snoop_bcast_if.slave bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    snoop_state_t           state;
    logic [CNT_W-1:0]       wd_cnt;
    logic                   req_ready_q;
    logic [ADDR_WIDTH-1:0]  acaddr_q;
    logic [3:0]             acsnoop_q;
    logic                   snoop_complete_q;
    logic                   timeout_err_q;

    logic                   accept;
    logic                   all_set;
    logic                   timeout_fire;
    logic                   release_hold;
    logic [NUM_MASTERS-1:0] cr_hs;
    logic [NUM_MASTERS-1:0] src_match;

    assign accept       = (state == ST_IDLE) && req_ready_q && bus.req_valid;
    // Counts responses landing this cycle so HOLD is entered right after the last CR handshake.
    assign all_set      = &(bus.crresp_vld | cr_hs);
    assign timeout_fire = (state == ST_ACTIVE) && !all_set && (wd_cnt == WD_LAST);
    assign release_hold = (state == ST_HOLD) && bus.release_pulse;

    assign bus.req_ready      = req_ready_q;
    assign bus.acaddr         = acaddr_q;
    assign bus.acsnoop        = acsnoop_q;
    assign bus.snoop_complete = snoop_complete_q;
    assign bus.timeout_err    = timeout_err_q;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_port
        // An out-of-range req_src matches nothing, so every master is snooped.
        assign src_match[i] = (bus.req_src == MST_IDX_W'(i));

        snoop_port_trk u_trk (
            .ACLK         (ACLK),
            .ARESETn      (ARESETn),
            .start        (accept),
            .is_src       (src_match[i]),
            .clear        (release_hold),
            .timeout      (timeout_fire),
            .acready      (bus.acready[i]),
            .crvalid      (bus.crvalid[i]),
            .crresp       (bus.crresp[5*i +: 5]),
            .acvalid      (bus.acvalid[i]),
            .crready      (bus.crready[i]),
            .crresp_vld   (bus.crresp_vld[i]),
            .crresp_slice (bus.crresp_bus[5*i +: 5]),
            .cr_hs        (cr_hs[i])
        );
    end

    // Transaction FSM with watchdog and registered request/AC/status outputs.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state            <= ST_IDLE;
            wd_cnt           <= '0;
            req_ready_q      <= 1'b0;
            acaddr_q         <= '0;
            acsnoop_q        <= '0;
            snoop_complete_q <= 1'b0;
            timeout_err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        acaddr_q    <= bus.req_addr;
                        acsnoop_q   <= bus.req_snoop;
                        wd_cnt      <= '0;
                        req_ready_q <= 1'b0;
                        state       <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (all_set) begin
                        state            <= ST_HOLD;
                        snoop_complete_q <= 1'b1;
                    end else if (timeout_fire) begin
                        state            <= ST_HOLD;
                        snoop_complete_q <= 1'b1;
                        timeout_err_q    <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.release_pulse) begin
                        state            <= ST_IDLE;
                        req_ready_q      <= 1'b1;
                        snoop_complete_q <= 1'b0;
                        timeout_err_q    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
